// File: rtl/bopit_pkg.sv
// Shared types and constants for the Bop-it board LED bank.
package bopit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    CHASE = 2'd2
  } fx_state_t;

  localparam int LED_W = 16;
  localparam logic [LED_W-1:0] LED_ALL_ON  = 16'hFFFF;
  localparam logic [LED_W-1:0] LED_ALL_OFF = 16'h0000;

  // Idle score bar: the lowest `s` LEDs lit.
  function automatic logic [LED_W-1:0] score_bar(input logic [3:0] s);
    return (LED_W'(1) << s) - LED_W'(1);
  endfunction

endpackage

// File: rtl/led_fx_scheduler_tick_gen.sv
// Effect step prescaler: tick is high for the last cycle of every TICK_DIV-cycle window.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_fx_scheduler.sv
// LED bank owner: score bar when idle, whole-bank flash or single-LED chase on request.
module led_fx_scheduler
  import bopit_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int FLASH_COUNT = 3,
  parameter int CHASE_LAPS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_flash,
  input  logic        req_chase,
  input  logic [3:0]  score,
  output logic [15:0] led,
  output logic        busy,
  output logic        done
);

  // Requests are single-cycle pulses that need no acknowledge; busy is high
  // for the whole effect and done pulses in its last cycle on normal completion.
  localparam int PH_W  = (2 * FLASH_COUNT > 2) ? $clog2(2 * FLASH_COUNT) : 1;
  localparam int LAP_W = (CHASE_LAPS > 2) ? $clog2(CHASE_LAPS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * FLASH_COUNT - 1);
  localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(CHASE_LAPS - 1);

  fx_state_t        state;
  logic [PH_W-1:0]  phase;
  logic [3:0]       step;
  logic [LAP_W-1:0] lap;
  logic             pend_flash;
  logic             pend_chase;
  logic             tick;
  logic             flash_last;
  logic             chase_last;
  logic             launch_flash;
  logic             launch_chase;

  assign flash_last   = (phase == PH_LAST);
  assign chase_last   = (step == 4'd15) && (lap == LAP_LAST);
  assign launch_flash = ((state == IDLE) && (pend_flash || req_flash)) ||
                        ((state == CHASE) && req_flash);
  assign launch_chase = (state == IDLE) && !(pend_flash || req_flash) &&
                        (pend_chase || req_chase);

  // A flash request arriving on the chase's final tick aborts it, so no done.
  assign done = ((state == FLASH) && tick && flash_last) ||
                ((state == CHASE) && tick && chase_last && !req_flash);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (launch_flash || launch_chase),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      step       <= '0;
      lap        <= '0;
      pend_flash <= 1'b0;
      pend_chase <= 1'b0;
      busy       <= 1'b0;
      led        <= LED_ALL_OFF;
    end else begin
      if (launch_flash)                         pend_flash <= 1'b0;
      else if (req_flash && state != FLASH)     pend_flash <= 1'b1;
      if (launch_chase)                         pend_chase <= 1'b0;
      else if (req_chase && state != CHASE)     pend_chase <= 1'b1;

      case (state)
        IDLE: begin
          if (launch_flash) begin
            state <= FLASH;
            busy  <= 1'b1;
            phase <= '0;
            led   <= LED_ALL_ON;
          end else if (launch_chase) begin
            state <= CHASE;
            busy  <= 1'b1;
            step  <= '0;
            lap   <= '0;
            led   <= LED_W'(1);
          end else begin
            led <= score_bar(score);
          end
        end
        FLASH: begin
          if (tick) begin
            if (flash_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              phase <= '0;
              led   <= score_bar(score);
            end else begin
              phase <= phase + PH_W'(1);
              led   <= phase[0] ? LED_ALL_ON : LED_ALL_OFF;
            end
          end
        end
        CHASE: begin
          if (req_flash) begin
            state <= FLASH;
            phase <= '0;
            step  <= '0;
            lap   <= '0;
            led   <= LED_ALL_ON;
          end else if (tick) begin
            if (chase_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              step  <= '0;
              lap   <= '0;
              led   <= score_bar(score);
            end else begin
              step <= step + 4'd1;
              if (step == 4'd15) lap <= lap + LAP_W'(1);
              led  <= LED_W'(1) << (step + 4'd1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fx_scheduler.sv
// Bench for led_fx_scheduler: elapsed-time reference model checked every cycle, plus directed literal checks.
module tb_led_fx_scheduler;

  localparam int TD  = 4;
  localparam int FC  = 2;
  localparam int CL  = 1;
  localparam int FLASH_LEN = 2 * FC * TD;
  localparam int CHASE_LEN = 16 * CL * TD;
  localparam int M_IDLE  = 0;
  localparam int M_FLASH = 1;
  localparam int M_CHASE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_flash;
  logic        req_chase;
  logic [3:0]  score;
  logic [15:0] led;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic cmp_en = 1'b0;

  // reference model state: current effect and cycles elapsed inside it
  int          m_mode;
  int          m_t;
  logic        m_pend;
  logic [15:0] m_bar;

  led_fx_scheduler #(.TICK_DIV(TD), .FLASH_COUNT(FC), .CHASE_LAPS(CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_flash (req_flash),
    .req_chase (req_chase),
    .score     (score),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bar_of(input logic [3:0] s);
    int v;
    v = (1 << s) - 1;
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE;
      m_t    <= 0;
      m_pend <= 1'b0;
      m_bar  <= 16'h0000;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (req_flash) begin
            m_mode <= M_FLASH;
            m_t    <= 0;
            if (req_chase) m_pend <= 1'b1;
          end else if (m_pend || req_chase) begin
            m_mode <= M_CHASE;
            m_t    <= 0;
            m_pend <= 1'b0;
          end else begin
            m_bar <= bar_of(score);
          end
        end
        M_FLASH: begin
          if (req_chase) m_pend <= 1'b1;
          if (m_t == FLASH_LEN - 1) begin
            m_mode <= M_IDLE;
            m_bar  <= bar_of(score);
          end else begin
            m_t <= m_t + 1;
          end
        end
        default: begin
          if (req_flash) begin
            m_mode <= M_FLASH;
            m_t    <= 0;
          end else if (m_t == CHASE_LEN - 1) begin
            m_mode <= M_IDLE;
            m_bar  <= bar_of(score);
          end else begin
            m_t <= m_t + 1;
          end
        end
      endcase
    end
  end

  function automatic logic [15:0] exp_led();
    int sh;
    if (m_mode == M_IDLE)  return m_bar;
    if (m_mode == M_FLASH) return (((m_t / TD) % 2) == 1) ? 16'h0000 : 16'hFFFF;
    sh = (m_t / TD) % 16;
    return 16'(1 << sh);
  endfunction

  function automatic logic exp_done();
    if (m_mode == M_FLASH) return (m_t == FLASH_LEN - 1);
    if (m_mode == M_CHASE) return (m_t == CHASE_LEN - 1) && !req_flash;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_led",  32'(led),  32'(exp_led()));
      chk("model_busy", 32'(busy), 32'(m_mode != M_IDLE));
      chk("model_done", 32'(done), 32'(exp_done()));
      if (done === 1'b1) done_seen++;
    end
  end

  initial begin
    int d0;
    rst = 1'b1; req_flash = 1'b0; req_chase = 1'b0; score = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_led",  32'(led),  32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    cmp_en = 1'b1;
    cyc(); rst = 1'b0;
    cyc(); score = 4'd5;
    cyc(); @(negedge clk);
    chk("bar_score5", 32'(led), 32'h001F);

    // flash alone
    cyc(); req_flash = 1'b1;
    cyc(); req_flash = 1'b0; @(negedge clk);
    chk("flash_first_on", 32'(led), 32'hFFFF);
    repeat (4) cyc(); @(negedge clk);
    chk("flash_first_off", 32'(led), 32'h0000);
    repeat (11) cyc(); @(negedge clk);
    chk("flash_done", 32'(done), 32'h1);
    cyc(); @(negedge clk);
    chk("flash_back_bar",  32'(led),  32'h001F);
    chk("flash_back_busy", 32'(busy), 32'h0);

    // chase alone
    cyc(); req_chase = 1'b1;
    cyc(); req_chase = 1'b0; @(negedge clk);
    chk("chase_step0", 32'(led), 32'h0001);
    repeat (4) cyc(); @(negedge clk);
    chk("chase_step1", 32'(led), 32'h0002);
    repeat (59) cyc(); @(negedge clk);
    chk("chase_step15", 32'(led), 32'h8000);
    chk("chase_done", 32'(done), 32'h1);
    cyc(); @(negedge clk);
    chk("chase_idle_busy", 32'(busy), 32'h0);

    // flash preempts chase
    cyc(); req_chase = 1'b1;
    cyc(); req_chase = 1'b0;
    repeat (9) cyc(); req_flash = 1'b1; d0 = done_seen;
    cyc(); req_flash = 1'b0; @(negedge clk);
    chk("preempt_flash_on", 32'(led), 32'hFFFF);
    repeat (20) cyc(); @(negedge clk);
    chk("preempt_done_count", 32'(done_seen - d0), 32'h1);

    // simultaneous requests: flash, one idle bar cycle, then chase
    cyc(); req_flash = 1'b1; req_chase = 1'b1;
    cyc(); req_flash = 1'b0; req_chase = 1'b0; @(negedge clk);
    chk("both_flash_on", 32'(led), 32'hFFFF);
    repeat (15) cyc(); @(negedge clk);
    chk("both_flash_done", 32'(done), 32'h1);
    cyc(); @(negedge clk);
    chk("both_gap_bar",  32'(led),  32'h001F);
    chk("both_gap_busy", 32'(busy), 32'h0);
    cyc(); @(negedge clk);
    chk("both_chase_start", 32'(led),  32'h0001);
    chk("both_chase_busy",  32'(busy), 32'h1);
    repeat (70) cyc();

    // reset mid-flash discards pending chase
    cyc(); req_flash = 1'b1;
    cyc(); req_flash = 1'b0;
    repeat (2) cyc(); req_chase = 1'b1;
    cyc(); req_chase = 1'b0;
    repeat (6) cyc(); rst = 1'b1;
    #1;
    chk("midrst_led",  32'(led),  32'h0000);
    chk("midrst_busy", 32'(busy), 32'h0);
    cyc(); cyc(); rst = 1'b0;
    repeat (2) cyc(); @(negedge clk);
    chk("midrst_bar", 32'(led), 32'h001F);
    repeat (80) cyc(); @(negedge clk);
    chk("midrst_no_chase", 32'(busy), 32'h0);

    // score boundaries
    cyc(); score = 4'd15;
    cyc(); @(negedge clk);
    chk("bar_score15", 32'(led), 32'h7FFF);
    cyc(); score = 4'd0;
    cyc(); @(negedge clk);
    chk("bar_score0", 32'(led), 32'h0000);

    // random traffic against the model
    repeat (3000) begin
      cyc();
      req_flash = ($urandom_range(0, 99) < 3);
      req_chase = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 19) == 0) score = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 999) == 0);
    end
    cyc(); rst = 1'b0; req_flash = 1'b0; req_chase = 1'b0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
